actuator_bridge: RTL and testbench
==================================

# actuator_bridge

H-bridge gate-control stage for the linear actuator, sitting directly downstream of the `pwm` generator. It steers the single PWM stream onto one of two bridge inputs according to a direction request. It enforces dead-time on every direction change and stops motion at the synchronised end-of-travel limit switches. It latches a fault when both limits read active together.

## Interface
Parameters:
- `DEAD_CYCLES`, default 100: clocks of forced coast between any two drive states. Legal range is 1 to 65535.
- `SYNC_STAGES`, default 2: flop depth of the limit-switch synchronisers. Legal values are 2 or more.

Ports:
- `clk`, input, 1 bit: system clock.
- `reset`, input, 1 bit: asynchronous, active-low reset. All flops clear immediately on assertion.
- `en`, input, 1 bit: motion enable, synchronous to `clk`.
- `dir`, input, 1 bit: requested direction. 1 = extend, 0 = retract. Synchronous to `clk`.
- `pwm_in`, input, 1 bit: PWM stream from `pwm`. Synchronous to `clk`.
- `lim_ext`, input, 1 bit: extend end-stop, active-high, asynchronous pin.
- `lim_ret`, input, 1 bit: retract end-stop, active-high, asynchronous pin.
- `in_a`, output, 1 bit: bridge input A, registered. Driving it drives the actuator toward extend.
- `in_b`, output, 1 bit: bridge input B, registered. Driving it drives the actuator toward retract.
- `state`, output, 3 bits: current FSM state, for status display.
- `fault`, output, 1 bit: high exactly while in FAULT.

## Operation
- `lim_ext` and `lim_ret` each pass through a `SYNC_STAGES`-flop synchroniser, producing `le_s` and `lr_s`. All decisions use only the synchronised values.
- FSM states and encodings: COAST=0, DEAD=1, EXT=2, RET=3, FAULT=4.
- Fault condition: `le_s & lr_s`. It is evaluated in every state, takes priority over all other transitions, and moves the FSM to FAULT on the next clock.
- COAST:
  - Go to DEAD if `en` is high and the requested direction is not blocked by its limit.
  - Extend is blocked when `le_s` is high. Retract is blocked when `lr_s` is high.
- DEAD:
  - A down-counter loads `DEAD_CYCLES-1` on entry and decrements each cycle.
  - On the cycle where the counter is 0, the FSM re-evaluates the inputs at that moment:
    - EXT if `en & dir & ~le_s`;
    - else RET if `en & ~dir & ~lr_s`;
    - else COAST.
- EXT: go to DEAD when `~en`, `~dir`, or `le_s` is true.
- RET: go to DEAD when `~en`, `dir`, or `lr_s` is true.
- FAULT:
  - Hold until `en` is low and the fault condition has cleared.
  - Then go to COAST. Leaving COAST for any drive state still passes through DEAD.
- Output registers:
  - `in_a` <= (next_state==EXT) & `pwm_in`.
  - `in_b` <= (next_state==RET) & `pwm_in`.
- `in_a` and `in_b` are never both 1 under any input sequence.
- A `dir` toggle during DEAD does not restart the counter; the choice is made at count 0.

## Timing
- Reset values: `in_a`=0, `in_b`=0, `state`=COAST, `fault`=0, dead counter=0, all synchroniser flops=0.
- Latency from `pwm_in` to `in_a`/`in_b` while in a drive state: 1 clock.
- COAST to first possible driven edge: 1 cycle into DEAD, then `DEAD_CYCLES` cycles in DEAD.
- On any transition between EXT and RET, both outputs are 0 for at least `DEAD_CYCLES` consecutive cycles.
- Latency from a limit pin rising to the corresponding output forced low: `SYNC_STAGES`+1 clocks.
- Latency from the fault condition to both outputs at 0: `SYNC_STAGES`+1 clocks. FAULT is entered directly from EXT or RET, with no DEAD in between.
- Reset asserted mid-drive clears the outputs asynchronously in the same cycle. After release the FSM restarts from COAST.
- `en` dropping has an effect one clock later: the FSM enters DEAD and the outputs go to 0.

## Structure
- Package `actuator_pkg` holds the state enum and its encodings, plus the `DIR_EXTEND`/`DIR_RETRACT` constants. The package is shared with the status display logic.
- Sub-module `sync_ff`: a parameterised n-stage synchroniser with asynchronous active-low reset. It is instantiated once per limit input and is reusable for the push-button inputs.
- The FSM, dead counter and output registers live in `actuator_bridge`.

## Test plan
- **Reset, then extend:** reset, then `en`=1, `dir`=1 with 50% `pwm_in`, `DEAD_CYCLES`=4. Required: `in_b` stays 0. `in_a` stays 0 for 5 cycles, then follows `pwm_in` delayed by 1 clock. `state` sequence is 0→1→2.
- **Direction reversal mid-drive:** in EXT, with `pwm_in` held at 1, toggle `dir` to 0. Required: `in_a` falls 1 clock later. Both outputs are 0 for exactly 4 cycles. `in_b` then rises. No overlap of `in_a` and `in_b` in any cycle.
- **Extend limit:** in EXT, assert `lim_ext`. Required: `in_a`=0 after 3 clocks, FSM passes DEAD→COAST. A later request with `dir`=1 stays in COAST; a request with `dir`=0 proceeds to RET.
- **Fault:** while driving, assert both limits. Required: `fault`=1 and both outputs 0 after 3 clocks. FAULT holds while `en`=1 even after the limits clear. With `en`=0 and the limits clear, the next state is COAST.
- **Asynchronous reset mid-drive:** drop `reset` between clock edges while in RET. Required: `in_b`=0 without waiting for a clock edge. After reset releases, `state`=0.
- **Enable glitch during DEAD:** in DEAD, drop `en` for 1 cycle at count 2, then restore it before count 0. Required: at count 0, `en`=1 is sampled and the FSM enters the drive state matching the current `dir`. No counter restart.

Source files
------------

// File: rtl/actuator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : actuator_pkg
// Description : Shared types and constants for the actuator H-bridge stage
//               and the status display logic that decodes its state.
// Revision    : 1.0 - initial release
// ============================================================================
package actuator_pkg;

    // Bridge FSM states; encodings are visible on the status port.
    typedef enum logic [2:0] {
        ST_COAST = 3'd0,
        ST_DEAD  = 3'd1,
        ST_EXT   = 3'd2,
        ST_RET   = 3'd3,
        ST_FAULT = 3'd4
    } act_state_e;

    // Meaning of the dir request input.
    localparam logic DIR_EXTEND  = 1'b1;
    localparam logic DIR_RETRACT = 1'b0;

    // Width of the dead-time down-counter (covers DEAD_CYCLES up to 65535).
    localparam int CNT_W = 16;

endpackage : actuator_pkg
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : N-stage flop synchroniser for asynchronous input pins.
//               Asynchronous active-low reset clears every stage.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;
    logic [STAGES-1:0][WIDTH-1:0] sync_d;

    // Shift the raw pin in at stage 0 and advance every stage by one.
    always_comb begin
        sync_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser chain registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/actuator_bridge.sv
`default_nettype none
// ============================================================================
// Module      : actuator_bridge
// Description : H-bridge gate control. Steers the PWM stream onto bridge
//               input A (extend) or B (retract), forces dead-time between
//               drive states, honours end-of-travel limits and latches a
//               fault when both limits read active together.
// Revision    : 1.0 - initial release
// ============================================================================
module actuator_bridge
    import actuator_pkg::*;
#(
    parameter int DEAD_CYCLES = 100,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       pwm_in,
    input  logic       lim_ext,
    input  logic       lim_ret,
    output logic       in_a,
    output logic       in_b,
    output logic [2:0] state,
    output logic       fault
);

    localparam logic [CNT_W-1:0] c_DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

    logic              le_s;
    logic              lr_s;
    logic              fault_cond;
    logic              ext_ok;
    logic              ret_ok;

    act_state_e        state_q;
    act_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              in_a_q;
    logic              in_a_d;
    logic              in_b_q;
    logic              in_b_d;

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_sync_ext (
        .clk    (clk),
        .rst_n  (reset),
        .d      (lim_ext),
        .q      (le_s)
    );

    sync_ff #(
        .STAGES (SYNC_STAGES),
        .WIDTH  (1)
    ) u_sync_ret (
        .clk    (clk),
        .rst_n  (reset),
        .d      (lim_ret),
        .q      (lr_s)
    );

    // A direction is only drivable when enabled and its end-stop is clear.
    assign fault_cond = le_s & lr_s;
    assign ext_ok     = en & (dir == DIR_EXTEND)  & ~le_s;
    assign ret_ok     = en & (dir == DIR_RETRACT) & ~lr_s;

    // Next-state, dead counter and gated PWM outputs; fault overrides all.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;

        if (fault_cond) begin
            state_d = ST_FAULT;
        end else begin
            case (state_q)
                ST_COAST: begin
                    if (ext_ok || ret_ok) begin
                        state_d = ST_DEAD;
                    end
                end
                ST_DEAD: begin
                    // Direction is chosen only when the count expires.
                    if (cnt_q == '0) begin
                        if (ext_ok) begin
                            state_d = ST_EXT;
                        end else if (ret_ok) begin
                            state_d = ST_RET;
                        end else begin
                            state_d = ST_COAST;
                        end
                    end
                end
                ST_EXT: begin
                    if (!ext_ok) begin
                        state_d = ST_DEAD;
                    end
                end
                ST_RET: begin
                    if (!ret_ok) begin
                        state_d = ST_DEAD;
                    end
                end
                ST_FAULT: begin
                    if (!en) begin
                        state_d = ST_COAST;
                    end
                end
                default: begin
                    state_d = ST_COAST;
                end
            endcase
        end

        // Load on entry to DEAD, count down while staying; DEAD never
        // persists past zero, so the decrement cannot wrap.
        if (state_d == ST_DEAD) begin
            if (state_q != ST_DEAD) begin
                cnt_d = c_DEAD_LOAD;
            end else begin
                cnt_d = cnt_q - c_ONE;
            end
        end

        in_a_d = (state_d == ST_EXT) & pwm_in;
        in_b_d = (state_d == ST_RET) & pwm_in;
    end

    // FSM, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_COAST;
            cnt_q   <= '0;
            in_a_q  <= 1'b0;
            in_b_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
        end
    end

    assign in_a  = in_a_q;
    assign in_b  = in_b_q;
    assign state = state_q;
    assign fault = (state_q == ST_FAULT);

endmodule : actuator_bridge
`default_nettype wire

// File: tb/tb_actuator_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_actuator_bridge
// Description : Self-checking bench for actuator_bridge: directed scenarios
//               with literal expectations plus a randomized phase compared
//               every cycle against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_actuator_bridge;

    localparam int DEAD = 4;
    localparam int SYNC = 2;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       en      = 1'b0;
    logic       dir     = 1'b0;
    logic       pwm_in  = 1'b0;
    logic       lim_ext = 1'b0;
    logic       lim_ret = 1'b0;
    logic       in_a;
    logic       in_b;
    logic [2:0] state;
    logic       fault;

    int checks = 0;
    int errors = 0;
    bit pwm_toggle = 1'b0;

    // Behavioural model state: 0 coast, 1 dead, 2 extend, 3 retract, 4 fault.
    int m_state;
    int m_dead;
    bit m_a;
    bit m_b;
    bit le_p [SYNC];
    bit lr_p [SYNC];
    int last_side;
    int zero_run;

    // Free-running clock.
    always #5 clk = ~clk;

    actuator_bridge #(
        .DEAD_CYCLES (DEAD),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .dir     (dir),
        .pwm_in  (pwm_in),
        .lim_ext (lim_ext),
        .lim_ret (lim_ret),
        .in_a    (in_a),
        .in_b    (in_b),
        .state   (state),
        .fault   (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state   = 0;
        m_dead    = 0;
        m_a       = 1'b0;
        m_b       = 1'b0;
        last_side = 0;
        zero_run  = 0;
        for (int i = 0; i < SYNC; i++) begin
            le_p[i] = 1'b0;
            lr_p[i] = 1'b0;
        end
    endtask

    // One clock of the specified behaviour, from the values seen at the edge.
    task automatic model_step(input bit e, input bit d, input bit p, input bit le, input bit lr);
        bit les, lrs, want_ext, want_ret;
        int ns;
        les      = le_p[SYNC-1];
        lrs      = lr_p[SYNC-1];
        want_ext = e && d && !les;
        want_ret = e && !d && !lrs;
        ns       = m_state;
        if (les && lrs)              ns = 4;
        else if (m_state == 0)       ns = (want_ext || want_ret) ? 1 : 0;
        else if (m_state == 1)       ns = (m_dead > 0) ? 1 : (want_ext ? 2 : (want_ret ? 3 : 0));
        else if (m_state == 2)       ns = want_ext ? 2 : 1;
        else if (m_state == 3)       ns = want_ret ? 3 : 1;
        else                         ns = e ? 4 : 0;
        if (ns == 1 && m_state != 1) m_dead = DEAD - 1;
        else if (ns == 1)            m_dead = m_dead - 1;
        m_state = ns;
        m_a = (ns == 2) && p;
        m_b = (ns == 3) && p;
        for (int i = SYNC - 1; i > 0; i--) begin
            le_p[i] = le_p[i-1];
            lr_p[i] = lr_p[i-1];
        end
        le_p[0] = le;
        lr_p[0] = lr;
    endtask

    // Per-cycle comparison of the DUT against the model.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (!reset) model_reset();
            else        model_step(en, dir, pwm_in, lim_ext, lim_ret);
            #1;
            check("model_state", state, m_state);
            check("model_in_a", in_a, m_a);
            check("model_in_b", in_b, m_b);
            check("model_fault", fault, m_state == 4);
            check("no_overlap", in_a & in_b, 0);
            if (in_a || in_b) begin
                if (last_side != 0 && last_side != (in_a ? 1 : 2))
                    check("dead_gap", zero_run >= DEAD, 1);
                last_side = in_a ? 1 : 2;
                zero_run  = 0;
            end else begin
                zero_run++;
            end
        end
    end

    // 50% PWM source when enabled.
    initial begin
        forever begin
            @(negedge clk);
            if (pwm_toggle) pwm_in = ~pwm_in;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int zeros;
        int rise;
        logic p;

        // Reset state
        tick(3);
        check("rst_state", state, 0);
        check("rst_in_a", in_a, 0);
        check("rst_in_b", in_b, 0);
        check("rst_fault", fault, 0);
        @(negedge clk); reset = 1'b1;

        // Reset, then extend with 50% PWM
        @(negedge clk); en = 1'b1; dir = 1'b1; pwm_toggle = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick(1);
            check("ext_dead_state", state, 1);
            check("ext_dead_in_a", in_a, 0);
        end
        @(posedge clk); p = pwm_in; #1;
        check("ext_state", state, 2);
        check("ext_follow_pwm", in_a, p);
        tick(4);

        // Direction reversal mid-drive, PWM held high
        @(negedge clk); pwm_toggle = 1'b0; pwm_in = 1'b1;
        tick(2);
        check("rev_pre_in_a", in_a, 1);
        @(negedge clk); dir = 1'b0;
        zeros = 0;
        rise  = -1;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (i == 1) check("rev_a_fall", in_a, 0);
            if (rise < 0) begin
                if (!in_a && !in_b) zeros++;
                else if (in_b)      rise = i;
            end
        end
        check("rev_zero_cycles", zeros, 4);
        check("rev_b_rise", rise, 5);

        // Extend limit
        @(negedge clk); dir = 1'b1;
        tick(6);
        check("lim_in_ext", state, 2);
        @(negedge clk); lim_ext = 1'b1;
        tick(2);
        check("lim_a_still", in_a, 1);
        tick(1);
        check("lim_a_low", in_a, 0);
        check("lim_dead", state, 1);
        tick(4);
        check("lim_coast", state, 0);
        tick(6);
        check("lim_blocked", state, 0);
        @(negedge clk); dir = 1'b0;
        tick(5);
        check("lim_ret_ok", state, 3);
        check("lim_ret_b", in_b, 1);
        @(negedge clk); lim_ext = 1'b0;

        // Fault: both limits while driving
        @(negedge clk); lim_ext = 1'b1; lim_ret = 1'b1;
        tick(2);
        check("flt_not_yet", fault, 0);
        tick(1);
        check("flt_fault", fault, 1);
        check("flt_in_b", in_b, 0);
        check("flt_state", state, 4);
        @(negedge clk); lim_ext = 1'b0; lim_ret = 1'b0;
        tick(6);
        check("flt_hold", state, 4);
        @(negedge clk); en = 1'b0;
        tick(1);
        check("flt_exit", state, 0);
        check("flt_clear", fault, 0);

        // Asynchronous reset mid-drive
        @(negedge clk); en = 1'b1; dir = 1'b0;
        tick(6);
        check("arst_in_ret", state, 3);
        check("arst_b_high", in_b, 1);
        @(negedge clk); #2 reset = 1'b0;
        #1;
        check("arst_b_async", in_b, 0);
        check("arst_state_async", state, 0);
        @(negedge clk); en = 1'b0;
        @(negedge clk); reset = 1'b1;
        #1;
        check("arst_after", state, 0);
        tick(2);

        // Enable glitch during DEAD, same direction
        @(negedge clk); en = 1'b1; dir = 1'b1;
        tick(2);
        check("gl_dead_c2", state, 1);
        @(negedge clk); en = 1'b0;
        tick(1);
        check("gl_dead_c1", state, 1);
        @(negedge clk); en = 1'b1;
        tick(1);
        check("gl_dead_c0", state, 1);
        tick(1);
        check("gl_ext", state, 2);
        @(negedge clk); en = 1'b0;
        tick(7);
        check("gl_back_coast", state, 0);

        // Enable glitch plus dir change during DEAD
        @(negedge clk); en = 1'b1; dir = 1'b1;
        tick(2);
        @(negedge clk); en = 1'b0;
        tick(1);
        @(negedge clk); en = 1'b1; dir = 1'b0;
        tick(2);
        check("gl_ret", state, 3);

        // Randomized traffic checked by the per-cycle model compare
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            en     = ($urandom_range(0, 7) != 0);
            pwm_in = $urandom_range(0, 1) != 0;
            if ($urandom_range(0, 15) == 0) dir = ~dir;
            if ($urandom_range(0, 39) == 0) lim_ext = ~lim_ext;
            if ($urandom_range(0, 39) == 0) lim_ret = ~lim_ret;
        end
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_actuator_bridge
`default_nettype wire
